// File: rtl/rv0_rf_f_wb_ctl.sv
// FP register-file write-back controller: round-robin arbitration of result producers onto the
// single write port, plus a 32-entry pending-write scoreboard that stalls issue on RAW/WAW hazards.

module rv0_rf_f_wb_ctl #(
    parameter int FLEN = 32,
    parameter int NREQ = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   iss_vld_i,
    input  logic [4:0]             iss_rd_i,
    input  logic [14:0]            iss_rs_i,
    input  logic [2:0]             iss_rs_use_i,
    output logic                   iss_stall_o,
    input  logic [NREQ-1:0]        req_vld_i,
    input  logic [NREQ*5-1:0]      req_rd_i,
    input  logic [NREQ*FLEN-1:0]   req_data_i,
    output logic [NREQ-1:0]        req_rdy_o,
    output logic                   rf_we_o,
    output logic [4:0]             rf_waddr_o,
    output logic [FLEN-1:0]        rf_wdata_o
);
    localparam int PW  = $clog2(NREQ);
    localparam int PW1 = PW + 1;

    logic [PW-1:0]   rr_ptr_r;
    logic [PW-1:0]   rr_nxt_s;
    logic [PW-1:0]   idx_s;
    logic [PW-1:0]   win_s;
    logic [PW1-1:0]  sum_s;
    logic            found_s;
    logic [NREQ-1:0] gnt_s;
    logic            xfer_s;
    logic [4:0]      g_rd_s;
    logic [FLEN-1:0] g_data_s;
    logic [4:0]      rd_a   [NREQ];
    logic [FLEN-1:0] data_a [NREQ];

    logic [31:0]     pending_r;
    logic [31:0]     clr_s;
    logic [31:0]     eff_s;
    logic [31:0]     set_s;
    logic            src_hit_s;
    logic            stall_s;
    logic            accept_s;

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign rd_a[k]   = req_rd_i[k*5 +: 5];
        assign data_a[k] = req_data_i[k*FLEN +: FLEN];
    end

    // Round-robin search starting at rr_ptr_r; the first valid requester in rotated order wins.
    always_comb begin
        found_s = 1'b0;
        win_s   = {PW{1'b0}};
        idx_s   = {PW{1'b0}};
        sum_s   = {PW1{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sum_s   = {1'b0, rr_ptr_r} + PW1'(i);
            idx_s   = (sum_s >= PW1'(NREQ)) ? PW'(sum_s - PW1'(NREQ)) : sum_s[PW-1:0];
            win_s   = (found_s || !req_vld_i[idx_s]) ? win_s : idx_s;
            found_s = found_s | req_vld_i[idx_s];
        end
        xfer_s = found_s;
        if (found_s) begin
            gnt_s        = {NREQ{1'b0}};
            gnt_s[win_s] = 1'b1;
            g_rd_s       = rd_a[win_s];
            g_data_s     = data_a[win_s];
            rr_nxt_s     = (win_s == PW'(NREQ - 1)) ? {PW{1'b0}} : win_s + PW'(1);
        end else begin
            gnt_s    = {NREQ{1'b0}};
            g_rd_s   = 5'd0;
            g_data_s = {FLEN{1'b0}};
            rr_nxt_s = rr_ptr_r;
        end
    end

    // Hazard check; the write retiring this cycle already counts as complete (bypass).
    always_comb begin
        clr_s     = rf_we_o ? (32'd1 << rf_waddr_o) : 32'd0;
        eff_s     = pending_r & ~clr_s;
        src_hit_s = (iss_rs_use_i[0] & eff_s[iss_rs_i[4:0]])
                  | (iss_rs_use_i[1] & eff_s[iss_rs_i[9:5]])
                  | (iss_rs_use_i[2] & eff_s[iss_rs_i[14:10]]);
        stall_s   = iss_vld_i & ~flush_i & (eff_s[iss_rd_i] | src_hit_s);
        accept_s  = iss_vld_i & ~flush_i & ~stall_s;
        set_s     = accept_s ? (32'd1 << iss_rd_i) : 32'd0;
    end

    assign iss_stall_o = stall_s;
    assign req_rdy_o   = gnt_s;

    // Registered write port and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= 5'd0;
            rf_wdata_o <= {FLEN{1'b0}};
            rr_ptr_r   <= {PW{1'b0}};
        end else begin
            rf_we_o  <= xfer_s;
            rr_ptr_r <= rr_nxt_s;
            if (xfer_s) begin
                rf_waddr_o <= g_rd_s;
                rf_wdata_o <= g_data_s;
            end
        end
    end

    // Pending-write scoreboard; a new issue wins over a retiring write to the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 32'd0;
        end else if (flush_i) begin
            pending_r <= 32'd0;
        end else begin
            pending_r <= eff_s | set_s;
        end
    end

    rv0_rf_f_wb_ctl_chk #(
        .FLEN (FLEN),
        .NREQ (NREQ)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .iss_vld_i   (iss_vld_i),
        .iss_rd_i    (iss_rd_i),
        .iss_stall_o (iss_stall_o),
        .req_vld_i   (req_vld_i),
        .req_rd_i    (req_rd_i),
        .req_data_i  (req_data_i),
        .req_rdy_o   (req_rdy_o),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .pending     (pending_r)
    );

endmodule

// Protocol and scoreboard-consistency assertions for rv0_rf_f_wb_ctl.
module rv0_rf_f_wb_ctl_chk #(
    parameter int FLEN = 32,
    parameter int NREQ = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 iss_vld_i,
    input  logic [4:0]           iss_rd_i,
    input  logic                 iss_stall_o,
    input  logic [NREQ-1:0]      req_vld_i,
    input  logic [NREQ*5-1:0]    req_rd_i,
    input  logic [NREQ*FLEN-1:0] req_data_i,
    input  logic [NREQ-1:0]      req_rdy_o,
    input  logic                 rf_we_o,
    input  logic [4:0]           rf_waddr_o,
    input  logic [31:0]          pending
);
    logic [31:0] flushed_r;

    // Registers whose pending bit may have been dropped by a flush or reset since their last issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flushed_r <= {32{1'b1}};
        end else if (flush_i) begin
            flushed_r <= {32{1'b1}};
        end else if (iss_vld_i && !iss_stall_o) begin
            flushed_r <= flushed_r & ~(32'd1 << iss_rd_i);
        end
    end

    a_wr_pending: assert property (@(posedge clk) disable iff (!rst_n)
        rf_we_o |-> (pending[rf_waddr_o] || flushed_r[rf_waddr_o]));

    a_rdy_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_rdy_o));

    for (genvar k = 0; k < NREQ; k++) begin : g_hold
        a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (req_vld_i[k] && !req_rdy_o[k] && !flush_i) |=>
            (req_vld_i[k] && $stable(req_rd_i[k*5 +: 5]) && $stable(req_data_i[k*FLEN +: FLEN])));
    end

endmodule

// File: tb/tb_rv0_rf_f_wb_ctl.sv
// Directed, table-driven bench for rv0_rf_f_wb_ctl (FLEN=32, NREQ=3) with hand-computed expectations.

module tb_rv0_rf_f_wb_ctl;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        iss_vld_i;
    logic [4:0]  iss_rd_i;
    logic [14:0] iss_rs_i;
    logic [2:0]  iss_rs_use_i;
    logic        iss_stall_o;
    logic [2:0]  req_vld_i;
    logic [14:0] req_rd_i;
    logic [95:0] req_data_i;
    logic [2:0]  req_rdy_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    int checks = 0;
    int errors = 0;

    rv0_rf_f_wb_ctl #(.FLEN(32), .NREQ(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .iss_vld_i    (iss_vld_i),
        .iss_rd_i     (iss_rd_i),
        .iss_rs_i     (iss_rs_i),
        .iss_rs_use_i (iss_rs_use_i),
        .iss_stall_o  (iss_stall_o),
        .req_vld_i    (req_vld_i),
        .req_rd_i     (req_rd_i),
        .req_data_i   (req_data_i),
        .req_rdy_o    (req_rdy_o),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        fl;
        logic        iv;
        logic [4:0]  ird;
        logic [14:0] irs;
        logic [2:0]  iu;
        logic [2:0]  vl;
        logic [14:0] rd;
        logic [95:0] dt;
        logic        e_stall;
        logic [2:0]  e_rdy;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic fl, input logic iv, input logic [4:0] ird,
                                input logic [14:0] irs, input logic [2:0] iu, input logic [2:0] vl,
                                input logic [14:0] rd, input logic [95:0] dt, input logic es,
                                input logic [2:0] er, input logic ew, input logic [4:0] ea,
                                input logic [31:0] ed);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ird = ird; v.irs = irs; v.iu = iu;
        v.vl = vl; v.rd = rd; v.dt = dt;
        v.e_stall = es; v.e_rdy = er; v.e_we = ew; v.e_waddr = ea; v.e_wdata = ed;
        return v;
    endfunction

    function automatic vec_t idl(input logic ew, input logic [4:0] ea, input logic [31:0] ed);
        return mk(1'b0, 1'b0, 5'd0, 15'd0, 3'd0, 3'd0, 15'd0, 96'd0, 1'b0, 3'd0, ew, ea, ed);
    endfunction

    function automatic vec_t iss(input logic [4:0] ird, input logic [14:0] irs, input logic [2:0] iu,
                                 input logic es, input logic ew, input logic [4:0] ea,
                                 input logic [31:0] ed);
        return mk(1'b0, 1'b1, ird, irs, iu, 3'd0, 15'd0, 96'd0, es, 3'd0, ew, ea, ed);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush_i = 1'b0; iss_vld_i = 1'b0; iss_rd_i = 5'd0; iss_rs_i = 15'd0; iss_rs_use_i = 3'd0;
        req_vld_i = 3'd0; req_rd_i = 15'd0; req_data_i = 96'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Round-robin: all three valid for six cycles, then drain; order 0,1,2,0,1,2,...
        tv.push_back(mk(1'b0,1'b0,5'd0,15'd0,3'd0, 3'b111, {5'd8,5'd2,5'd1},
            {32'h33333333,32'h22222222,32'h11111111}, 1'b0,3'b001, 1'b0,5'd0,32'h0));
        tv.push_back(mk(1'b0,1'b0,5'd0,15'd0,3'd0, 3'b111, {5'd8,5'd2,5'd16},
            {32'h33333333,32'h22222222,32'h44444444}, 1'b0,3'b010, 1'b1,5'd1,32'h11111111));
        tv.push_back(mk(1'b0,1'b0,5'd0,15'd0,3'd0, 3'b111, {5'd8,5'd17,5'd16},
            {32'h33333333,32'h55555555,32'h44444444}, 1'b0,3'b100, 1'b1,5'd2,32'h22222222));
        tv.push_back(mk(1'b0,1'b0,5'd0,15'd0,3'd0, 3'b111, {5'd18,5'd17,5'd16},
            {32'h66666666,32'h55555555,32'h44444444}, 1'b0,3'b001, 1'b1,5'd8,32'h33333333));
        tv.push_back(mk(1'b0,1'b0,5'd0,15'd0,3'd0, 3'b111, {5'd18,5'd17,5'd19},
            {32'h66666666,32'h55555555,32'h77777777}, 1'b0,3'b010, 1'b1,5'd16,32'h44444444));
        tv.push_back(mk(1'b0,1'b0,5'd0,15'd0,3'd0, 3'b111, {5'd18,5'd20,5'd19},
            {32'h66666666,32'h88888888,32'h77777777}, 1'b0,3'b100, 1'b1,5'd17,32'h55555555));
        tv.push_back(mk(1'b0,1'b0,5'd0,15'd0,3'd0, 3'b011, {5'd0,5'd20,5'd19},
            {32'h0,32'h88888888,32'h77777777}, 1'b0,3'b001, 1'b1,5'd18,32'h66666666));
        tv.push_back(mk(1'b0,1'b0,5'd0,15'd0,3'd0, 3'b010, {5'd0,5'd20,5'd0},
            {32'h0,32'h88888888,32'h0}, 1'b0,3'b010, 1'b1,5'd19,32'h77777777));
        tv.push_back(idl(1'b1, 5'd20, 32'h88888888));
        // Idle hold: outputs keep last address/data, pointer stays at 2.
        for (int i = 0; i < 4; i++) tv.push_back(idl(1'b0, 5'd20, 32'h88888888));
        tv.push_back(mk(1'b0,1'b0,5'd0,15'd0,3'd0, 3'b111, {5'd23,5'd22,5'd21},
            {32'hAAAA0003,32'hAAAA0002,32'hAAAA0001}, 1'b0,3'b100, 1'b0,5'd20,32'h88888888));
        tv.push_back(mk(1'b0,1'b0,5'd0,15'd0,3'd0, 3'b011, {5'd0,5'd22,5'd21},
            {32'h0,32'hAAAA0002,32'hAAAA0001}, 1'b0,3'b001, 1'b1,5'd23,32'hAAAA0003));
        tv.push_back(mk(1'b0,1'b0,5'd0,15'd0,3'd0, 3'b010, {5'd0,5'd22,5'd0},
            {32'h0,32'hAAAA0002,32'h0}, 1'b0,3'b010, 1'b1,5'd21,32'hAAAA0001));
        tv.push_back(idl(1'b1, 5'd22, 32'hAAAA0002));
        tv.push_back(idl(1'b0, 5'd22, 32'hAAAA0002));
        // RAW stall on f3 until its write retires (bypass in the write cycle).
        tv.push_back(iss(5'd3, 15'd0, 3'b000, 1'b0, 1'b0, 5'd22, 32'hAAAA0002));
        tv.push_back(iss(5'd10, {5'd0,5'd0,5'd3}, 3'b001, 1'b1, 1'b0, 5'd22, 32'hAAAA0002));
        tv.push_back(mk(1'b0,1'b1,5'd10,{5'd0,5'd0,5'd3},3'b001, 3'b001, {5'd0,5'd0,5'd3},
            {32'h0,32'h0,32'h40400000}, 1'b1,3'b001, 1'b0,5'd22,32'hAAAA0002));
        tv.push_back(iss(5'd10, {5'd0,5'd0,5'd3}, 3'b001, 1'b0, 1'b1, 5'd3, 32'h40400000));
        tv.push_back(idl(1'b0, 5'd3, 32'h40400000));
        tv.push_back(iss(5'd10, 15'd0, 3'b000, 1'b1, 1'b0, 5'd3, 32'h40400000));
        tv.push_back(iss(5'd11, {5'd10,5'd0,5'd0}, 3'b100, 1'b1, 1'b0, 5'd3, 32'h40400000));
        tv.push_back(iss(5'd11, {5'd10,5'd0,5'd0}, 3'b011, 1'b0, 1'b0, 5'd3, 32'h40400000));
        // WAW with set-wins: f7 retires in the same cycle a new rd=7 issues.
        tv.push_back(iss(5'd7, 15'd0, 3'b000, 1'b0, 1'b0, 5'd3, 32'h40400000));
        tv.push_back(mk(1'b0,1'b0,5'd0,15'd0,3'd0, 3'b010, {5'd0,5'd7,5'd0},
            {32'h0,32'h40E00000,32'h0}, 1'b0,3'b010, 1'b0,5'd3,32'h40400000));
        tv.push_back(iss(5'd7, 15'd0, 3'b000, 1'b0, 1'b1, 5'd7, 32'h40E00000));
        tv.push_back(iss(5'd7, 15'd0, 3'b000, 1'b1, 1'b0, 5'd7, 32'h40E00000));
        // Flush with simultaneous issue and a granted write that still completes.
        tv.push_back(mk(1'b1,1'b0,5'd0,15'd0,3'd0, 3'd0, 15'd0, 96'd0, 1'b0,3'd0, 1'b0,5'd7,32'h40E00000));
        tv.push_back(iss(5'd1, 15'd0, 3'b000, 1'b0, 1'b0, 5'd7, 32'h40E00000));
        tv.push_back(iss(5'd2, 15'd0, 3'b000, 1'b0, 1'b0, 5'd7, 32'h40E00000));
        tv.push_back(iss(5'd9, 15'd0, 3'b000, 1'b0, 1'b0, 5'd7, 32'h40E00000));
        tv.push_back(iss(5'd9, 15'd0, 3'b000, 1'b1, 1'b0, 5'd7, 32'h40E00000));
        tv.push_back(mk(1'b1,1'b1,5'd4,{5'd0,5'd0,5'd1},3'b001, 3'b100, {5'd9,5'd0,5'd0},
            {32'h41100000,32'h0,32'h0}, 1'b0,3'b100, 1'b0,5'd7,32'h40E00000));
        tv.push_back(iss(5'd5, {5'd0,5'd1,5'd4}, 3'b011, 1'b0, 1'b1, 5'd9, 32'h41100000));
        tv.push_back(idl(1'b0, 5'd9, 32'h41100000));

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst we", 32'(rf_we_o), 32'd0);
        chk("rst waddr", 32'(rf_waddr_o), 32'd0);
        chk("rst wdata", rf_wdata_o, 32'd0);
        chk("rst pending", dut.pending_r, 32'd0);
        chk("rst stall", 32'(iss_stall_o), 32'd0);
        chk("rst rdy", 32'(req_rdy_o), 32'd0);

        // Single req1 write.
        @(negedge clk);
        req_vld_i = 3'b010; req_rd_i = {5'd0,5'd5,5'd0}; req_data_i = {32'h0,32'h3F800000,32'h0};
        #1;
        chk("t1 rdy", 32'(req_rdy_o), 32'd2);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("t1 we", 32'(rf_we_o), 32'd1);
        chk("t1 waddr", 32'(rf_waddr_o), 32'd5);
        chk("t1 wdata", rf_wdata_o, 32'h3F800000);

        // Reset asserted while a write is on the port; transfer in the reset cycle is lost.
        @(negedge clk);
        req_vld_i = 3'b100; req_rd_i = {5'd6,5'd0,5'd0}; req_data_i = {32'h40000000,32'h0,32'h0};
        iss_vld_i = 1'b1; iss_rd_i = 5'd12;
        #1;
        chk("rr2 rdy", 32'(req_rdy_o), 32'd4);
        chk("iss12 stall", 32'(iss_stall_o), 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("pre-rst we", 32'(rf_we_o), 32'd1);
        chk("pre-rst waddr", 32'(rf_waddr_o), 32'd6);
        chk("pre-rst pending", dut.pending_r, 32'h00001000);
        rst_n = 1'b0;
        req_vld_i = 3'b001; req_rd_i = {5'd0,5'd0,5'd13}; req_data_i = {32'h0,32'h0,32'hDEADBEEF};
        #1;
        chk("mid-rst we", 32'(rf_we_o), 32'd0);
        chk("mid-rst waddr", 32'(rf_waddr_o), 32'd0);
        chk("mid-rst wdata", rf_wdata_o, 32'd0);
        chk("mid-rst pending", dut.pending_r, 32'd0);
        chk("mid-rst rr_ptr", 32'(dut.rr_ptr_r), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        #1;
        chk("post-rst we", 32'(rf_we_o), 32'd0);
        chk("post-rst wdata", rf_wdata_o, 32'd0);

        // Table-driven vectors.
        foreach (tv[i]) begin
            @(negedge clk);
            flush_i = tv[i].fl; iss_vld_i = tv[i].iv; iss_rd_i = tv[i].ird;
            iss_rs_i = tv[i].irs; iss_rs_use_i = tv[i].iu;
            req_vld_i = tv[i].vl; req_rd_i = tv[i].rd; req_data_i = tv[i].dt;
            #1;
            chk($sformatf("row%0d stall", i), 32'(iss_stall_o), 32'(tv[i].e_stall));
            chk($sformatf("row%0d rdy", i), 32'(req_rdy_o), 32'(tv[i].e_rdy));
            chk($sformatf("row%0d we", i), 32'(rf_we_o), 32'(tv[i].e_we));
            chk($sformatf("row%0d waddr", i), 32'(rf_waddr_o), 32'(tv[i].e_waddr));
            chk($sformatf("row%0d wdata", i), rf_wdata_o, tv[i].e_wdata);
        end

        // After the flush only f5 (issued the cycle after) is pending; pointer wrapped to 0.
        @(negedge clk);
        idle_inputs();
        #1;
        chk("final pending", dut.pending_r, 32'h00000020);
        chk("final rr_ptr", 32'(dut.rr_ptr_r), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
